// File: rtl/l1_cache_pkg.sv
// Purpose: shared widths, line/set/mask types and fill FSM states for the L1 data-array write side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l1_cache_pkg;

  localparam int L1_LINE_W     = 1024;
  localparam int L1_SET_W      = 8;
  localparam int L1_BEAT_W     = 64;
  localparam int L1_BEATS      = 16;
  localparam int L1_BEAT_IDX_W = $clog2(L1_BEATS);
  localparam int L1_WMASK_W    = L1_LINE_W / 8;

  typedef logic [L1_SET_W-1:0]   l1_set_t;
  typedef logic [L1_LINE_W-1:0]  l1_line_t;
  typedef logic [L1_WMASK_W-1:0] l1_wmask_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/l1_fill_buffer.sv
// Purpose: assembles one refill line from BEATS beats; counts beats and flags beat_last mismatches.
// Latency: beat visible on line_nxt combinationally in its accept cycle; beat_err one cycle after the beat.
// Backpressure: none of its own; the owner gates wr_en with its beat handshake.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (discards the partial line)
//   clr          start of a new refill: beat counter back to slot 0
//   wr_en        accepted beat; wr_data goes to slot cnt, cnt advances
//   wr_data      beat payload
//   wr_last      sender's end-of-line marker, compared against the count only
//   is_last      the next beat to arrive completes the line
//   line_nxt     buffer contents including the beat being accepted this cycle
//   beat_err     one-cycle pulse after a beat whose wr_last disagrees with the count
module l1_fill_buffer
  import l1_cache_pkg::*;
#(
  parameter int BEAT_WIDTH = L1_BEAT_W,
  parameter int BEATS      = L1_BEATS,
  parameter int BEAT_IDX_W = $clog2(BEATS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [BEAT_WIDTH-1:0]       wr_data,
  input  logic                        wr_last,
  output logic                        is_last,
  output logic [BEATS*BEAT_WIDTH-1:0] line_nxt,
  output logic                        beat_err
);

  logic [BEAT_IDX_W-1:0]       cnt_q;
  logic [BEATS*BEAT_WIDTH-1:0] line_q;

  assign is_last = (cnt_q == BEAT_IDX_W'(BEATS - 1));

  // Merge the incoming beat so the owner can write the complete line in the
  // same cycle the final beat is accepted.
  always_comb begin
    line_nxt = line_q;
    for (int i = 0; i < BEATS; i++) begin
      if (wr_en && (cnt_q == BEAT_IDX_W'(i))) begin
        line_nxt[i*BEAT_WIDTH +: BEAT_WIDTH] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      line_q   <= '0;
      beat_err <= 1'b0;
    end else begin
      beat_err <= wr_en && (wr_last != is_last);
      if (clr) begin
        cnt_q <= '0;
      end else if (wr_en) begin
        cnt_q  <= cnt_q + 1'b1;
        line_q <= line_nxt;
      end
    end
  end

endmodule

// File: rtl/l1_line_fill_writer.sv
// Purpose: L1 data-array write front end; merges line refills and byte-strobed stores onto one SRAM write port.
// Latency: store write 1 cycle after accept; refill write 17 cycles after accept with gap-free beats.
// Backpressure: readys drop outside IDLE; on a store/fill collision the round-robin loser's ready drops.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   fill_req_valid/ready/set        refill request and its target set
//   beat_valid/ready/data/last      refill beats, beat i lands at line bits [64*i +: 64]
//   store_valid/ready/set/offset    single-word store: set, 64-bit word index in the line
//   store_data/bstrb                store payload and byte strobes
//   sram_csb0/addr0/wmask0/din0     registered SRAM write port (csb0 active low)
//   wr_busy, wr_busy_set            refill in progress and its set, for read-side hazard checks
//   fill_done                       pulse coinciding with the refill's SRAM write
//   beat_err                        pulse after a beat_last that disagrees with the beat count
module l1_line_fill_writer
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = L1_LINE_W,
  parameter int ADDR_WIDTH = L1_SET_W,
  parameter int BEAT_WIDTH = L1_BEAT_W,
  parameter int NUM_WMASKS = DATA_WIDTH / 8,
  parameter int BEATS      = DATA_WIDTH / BEAT_WIDTH,
  parameter int BEAT_IDX_W = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fill_req_valid,
  output logic                    fill_req_ready,
  input  logic [ADDR_WIDTH-1:0]   fill_req_set,
  input  logic                    beat_valid,
  output logic                    beat_ready,
  input  logic [BEAT_WIDTH-1:0]   beat_data,
  input  logic                    beat_last,
  input  logic                    store_valid,
  output logic                    store_ready,
  input  logic [ADDR_WIDTH-1:0]   store_set,
  input  logic [BEAT_IDX_W-1:0]   store_offset,
  input  logic [BEAT_WIDTH-1:0]   store_data,
  input  logic [BEAT_WIDTH/8-1:0] store_bstrb,
  output logic                    sram_csb0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  output logic                    wr_busy,
  output logic [ADDR_WIDTH-1:0]   wr_busy_set,
  output logic                    fill_done,
  output logic                    beat_err
);

  localparam int BYTE_SH = $clog2(BEAT_WIDTH / 8);
  localparam int BIT_SH  = $clog2(BEAT_WIDTH);

  fill_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] set_q;
  logic                  rr_last_q;   // 1: the last grant went to the fill path
  logic                  ready_en_q;  // holds readys low until the first edge out of reset
  logic                  both_req;
  logic                  grant_fill;
  logic                  store_acc;
  logic                  fill_acc;
  logic                  beat_acc;
  logic                  last_beat_acc;
  logic                  buf_is_last;
  logic [DATA_WIDTH-1:0] buf_line_nxt;

  // Full-width shift indices so offset 15 reaches mask bit 127 / line bit 1023.
  logic [BEAT_IDX_W+BYTE_SH-1:0] byte_idx;
  logic [BEAT_IDX_W+BIT_SH-1:0]  bit_idx;
  logic [NUM_WMASKS-1:0]         store_wmask;
  logic [DATA_WIDTH-1:0]         store_din;

  logic                  csb_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic                  done_d;

  assign both_req   = store_valid && fill_req_valid;
  assign grant_fill = !rr_last_q;

  // FSM next state and handshake readys.
  always_comb begin
    state_d        = state_q;
    store_ready    = 1'b0;
    fill_req_ready = 1'b0;
    beat_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        store_ready    = ready_en_q && !(both_req && grant_fill);
        fill_req_ready = ready_en_q && !(both_req && !grant_fill);
        if (fill_req_valid && fill_req_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        beat_ready = 1'b1;
        if (beat_valid && buf_is_last) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign store_acc     = store_valid && store_ready;
  assign fill_acc      = fill_req_valid && fill_req_ready;
  assign beat_acc      = beat_valid && beat_ready;
  assign last_beat_acc = beat_acc && buf_is_last;

  assign byte_idx    = {store_offset, {BYTE_SH{1'b0}}};
  assign bit_idx     = {store_offset, {BIT_SH{1'b0}}};
  assign store_wmask = {{(NUM_WMASKS-BEAT_WIDTH/8){1'b0}}, store_bstrb} << byte_idx;
  assign store_din   = {{(DATA_WIDTH-BEAT_WIDTH){1'b0}}, store_data} << bit_idx;

  // Next SRAM port values. The fill write is loaded on the edge that takes the
  // last beat, so the registered port shows it while the FSM is in WRITE.
  always_comb begin
    csb_d   = 1'b1;
    addr_d  = sram_addr0;
    wmask_d = '0;
    din_d   = sram_din0;
    done_d  = 1'b0;
    if (store_acc) begin
      csb_d   = 1'b0;
      addr_d  = store_set;
      wmask_d = store_wmask;
      din_d   = store_din;
    end else if (last_beat_acc) begin
      csb_d   = 1'b0;
      addr_d  = set_q;
      wmask_d = '1;
      din_d   = buf_line_nxt;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0   <= 1'b1;
      sram_addr0  <= '0;
      sram_wmask0 <= '0;
      sram_din0   <= '0;
      fill_done   <= 1'b0;
      set_q       <= '0;
      rr_last_q   <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      sram_csb0   <= csb_d;
      sram_addr0  <= addr_d;
      sram_wmask0 <= wmask_d;
      sram_din0   <= din_d;
      fill_done   <= done_d;
      ready_en_q  <= 1'b1;
      if (fill_acc) begin
        set_q <= fill_req_set;
      end
      if (store_acc) begin
        rr_last_q <= 1'b0;
      end else if (fill_acc) begin
        rr_last_q <= 1'b1;
      end
    end
  end

  assign wr_busy     = (state_q == FILL) || (state_q == WRITE);
  assign wr_busy_set = set_q;

  l1_fill_buffer #(
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (BEATS),
    .BEAT_IDX_W (BEAT_IDX_W)
  ) u_fill_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (fill_acc),
    .wr_en    (beat_acc),
    .wr_data  (beat_data),
    .wr_last  (beat_last),
    .is_last  (buf_is_last),
    .line_nxt (buf_line_nxt),
    .beat_err (beat_err)
  );

endmodule

// File: tb/tb_l1_line_fill_writer.sv
module tb_l1_line_fill_writer;
  import l1_cache_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fill_req_valid = 1'b0;
  logic          fill_req_ready;
  logic [7:0]    fill_req_set = '0;
  logic          beat_valid = 1'b0;
  logic          beat_ready;
  logic [63:0]   beat_data = '0;
  logic          beat_last = 1'b0;
  logic          store_valid = 1'b0;
  logic          store_ready;
  logic [7:0]    store_set = '0;
  logic [3:0]    store_offset = '0;
  logic [63:0]   store_data = '0;
  logic [7:0]    store_bstrb = '0;
  logic          sram_csb0;
  logic [7:0]    sram_addr0;
  logic [127:0]  sram_wmask0;
  logic [1023:0] sram_din0;
  logic          wr_busy;
  logic [7:0]    wr_busy_set;
  logic          fill_done;
  logic          beat_err;

  always #5 clk = ~clk;

  l1_line_fill_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fill_req_valid (fill_req_valid),
    .fill_req_ready (fill_req_ready),
    .fill_req_set   (fill_req_set),
    .beat_valid     (beat_valid),
    .beat_ready     (beat_ready),
    .beat_data      (beat_data),
    .beat_last      (beat_last),
    .store_valid    (store_valid),
    .store_ready    (store_ready),
    .store_set      (store_set),
    .store_offset   (store_offset),
    .store_data     (store_data),
    .store_bstrb    (store_bstrb),
    .sram_csb0      (sram_csb0),
    .sram_addr0     (sram_addr0),
    .sram_wmask0    (sram_wmask0),
    .sram_din0      (sram_din0),
    .wr_busy        (wr_busy),
    .wr_busy_set    (wr_busy_set),
    .fill_done      (fill_done),
    .beat_err       (beat_err)
  );

  typedef struct {
    logic [7:0]    set;
    logic [127:0]  wmask;
    logic [1023:0] din;
    logic          done;
  } wr_t;

  typedef struct {
    logic [7:0]   set;
    logic [3:0]   off;
    logic [7:0]   bstrb;
    logic [63:0]  data;
    logic [127:0] exp_wmask;
  } st_t;

  wr_t exp_q[$];
  wr_t mon_e;
  st_t tab[5];
  st_t s_arb;

  int vectors   = 0;
  int fails     = 0;
  int cyc       = 0;
  int wr_cyc    = -1;
  int err_cnt   = 0;
  int err_cyc   = -1;
  int blk_viol  = 0;
  bit blk_watch = 1'b0;
  int beat_cyc[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk_store_exp(input st_t s);
    wr_t e;
    e.set   = s.set;
    e.wmask = s.exp_wmask;
    e.din   = '0;
    e.done  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (s.off == 4'(i)) e.din[64*i +: 64] = s.data;
    end
    return e;
  endfunction

  // Scoreboard: every csb0-low cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (beat_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (blk_watch && store_ready) blk_viol++;
    if (!sram_csb0) begin
      wr_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0h wmask=%0h", sram_addr0, sram_wmask0);
      end else begin
        mon_e = exp_q.pop_front();
        if (sram_addr0 !== mon_e.set || sram_wmask0 !== mon_e.wmask ||
            fill_done !== mon_e.done || sram_din0 !== mon_e.din) begin
          fails++;
          $display("FAIL sram_write addr act=%0h exp=%0h wmask act=%0h exp=%0h done act=%0b exp=%0b",
                   sram_addr0, mon_e.set, sram_wmask0, mon_e.wmask, fill_done, mon_e.done);
          for (int k = 0; k < 16; k++) begin
            if (sram_din0[64*k +: 64] !== mon_e.din[64*k +: 64])
              $display("  din slot %0d act=%0h exp=%0h", k, sram_din0[64*k +: 64], mon_e.din[64*k +: 64]);
          end
        end
      end
    end else if (sram_wmask0 !== '0 || fill_done !== 1'b0) begin
      vectors++;
      fails++;
      $display("FAIL idle_port wmask=%0h fill_done=%0b while csb0 high", sram_wmask0, fill_done);
    end
  end

  task automatic wait_rdy(input int which, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if ((which == 0 && store_ready) || (which == 1 && fill_req_ready) || (which == 2 && beat_ready)) begin
        ok = 1'b1;
        return;
      end
    end
    vectors++;
    fails++;
    $display("FAIL timeout_ready%0d act=0 exp=1", which);
  endtask

  task automatic do_store(input st_t s, output int c_acc);
    bit ok;
    store_valid  = 1'b1;
    store_set    = s.set;
    store_offset = s.off;
    store_bstrb  = s.bstrb;
    store_data   = s.data;
    wait_rdy(0, ok);
    if (ok) exp_q.push_back(mk_store_exp(s));
    @(posedge clk); #1;
    c_acc       = cyc;
    store_valid = 1'b0;
  endtask

  task automatic do_fill_req(input logic [7:0] set, output int c_acc);
    bit ok;
    fill_req_valid = 1'b1;
    fill_req_set   = set;
    wait_rdy(1, ok);
    @(posedge clk); #1;
    c_acc          = cyc;
    fill_req_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [7:0] set, input logic [31:0] seed, input int nbeats,
                            input logic [15:0] last_mask, input int gap_at, input int gap_len);
    wr_t e;
    bit  ok;
    e.set   = set;
    e.wmask = '1;
    e.din   = '0;
    e.done  = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin
        beat_valid = 1'b0;
        repeat (gap_len) begin
          @(posedge clk); #1;
        end
      end
      beat_valid = 1'b1;
      beat_data  = {seed, 32'(i)};
      beat_last  = last_mask[i];
      wait_rdy(2, ok);
      if (i == 0) chk("busy_set", {wr_busy, wr_busy_set}, {1'b1, set});
      e.din[64*i +: 64] = beat_data;
      if (i == 15) exp_q.push_back(e);
      @(posedge clk); #1;
      beat_cyc[i] = cyc;
    end
    beat_valid = 1'b0;
    beat_last  = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, cfirst, clast;
    bit ok;

    tab[0] = '{8'h03, 4'd15, 8'h81, 64'hAABB_0123_4567_CCDD, 128'h8100_0000_0000_0000_0000_0000_0000_0000};
    tab[1] = '{8'h00, 4'd0,  8'hFF, 64'h0123_4567_89AB_CDEF, 128'h0000_0000_0000_0000_0000_0000_0000_00FF};
    tab[2] = '{8'hFF, 4'd7,  8'h0F, 64'hFEDC_BA98_7654_3210, 128'h0000_0000_0000_0000_0F00_0000_0000_0000};
    tab[3] = '{8'h80, 4'd8,  8'h01, 64'h5555_6666_7777_8888, 128'h0000_0000_0000_0001_0000_0000_0000_0000};
    tab[4] = '{8'h41, 4'd1,  8'h80, 64'h1357_9BDF_2468_ACE0, 128'h0000_0000_0000_0000_0000_0000_0000_8000};
    s_arb  = '{8'h10, 4'd2,  8'h3C, 64'hCAFE_F00D_DEAD_BEEF, 128'h0000_0000_0000_0000_0000_0000_003C_0000};

    // Reset state, and readys held low until the first edge after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb",   sram_csb0, 1'b1);
    chk("rst_wmask", sram_wmask0, '0);
    chk("rst_addr",  sram_addr0, '0);
    chk("rst_din",   (sram_din0 == '0), 1'b1);
    chk("rst_rdy",   {store_ready, fill_req_ready, beat_ready}, 3'b000);
    chk("rst_flags", {wr_busy, fill_done, beat_err}, 3'b000);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", {store_ready, fill_req_ready}, 2'b00);
    @(posedge clk); #1;
    chk("rdy_after_edge", {store_ready, fill_req_ready, beat_ready}, 3'b110);

    // Gap-free fill of set 0x5A, beat i carries i.
    do_fill_req(8'h5A, c0);
    send_beats(8'h5A, 32'h0, 16, 16'h8000, -1, 0);
    drain();
    chk("fill_latency", wr_cyc, c0 + 16);
    chk("fill_idle_after", {wr_busy, store_ready}, 2'b01);

    // Single store, then back-to-back stores from the table.
    do_store(tab[0], c1);
    drain();
    chk("store_latency", wr_cyc, c1);
    chk("csb_one_cycle", sram_csb0, 1'b1);
    for (int i = 1; i < 5; i++) begin
      do_store(tab[i], c1);
      if (i == 1) cfirst = c1;
      clast = c1;
    end
    chk("b2b_one_per_cycle", clast - cfirst, 3);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Collision: store was granted last, so the fill wins; store blocked during the fill.
    store_valid    = 1'b1;
    store_set      = s_arb.set;
    store_offset   = s_arb.off;
    store_bstrb    = s_arb.bstrb;
    store_data     = s_arb.data;
    fill_req_valid = 1'b1;
    fill_req_set   = 8'h21;
    @(negedge clk);
    chk("arb1_grant_fill", {store_ready, fill_req_ready}, 2'b01);
    @(posedge clk); #1;
    fill_req_valid = 1'b0;
    blk_watch      = 1'b1;
    send_beats(8'h21, 32'h2121_0000, 16, 16'h8000, -1, 0);
    @(negedge clk);
    @(posedge clk); #1;
    blk_watch = 1'b0;
    chk("store_blocked_in_fill", blk_viol, 0);
    // Second collision: fill was granted last, so the store wins.
    fill_req_valid = 1'b1;
    fill_req_set   = 8'h22;
    @(negedge clk);
    chk("arb2_grant_store", {store_ready, fill_req_ready}, 2'b10);
    exp_q.push_back(mk_store_exp(s_arb));
    @(posedge clk); #1;
    store_valid = 1'b0;
    wait_rdy(1, ok);
    @(posedge clk); #1;
    fill_req_valid = 1'b0;
    send_beats(8'h22, 32'h2222_0000, 16, 16'h8000, -1, 0);
    drain();

    // A two-cycle gap in beat_valid stretches the fill by two cycles.
    do_fill_req(8'h77, c0);
    send_beats(8'h77, 32'hDEAD_0000, 16, 16'h8000, 5, 2);
    drain();
    chk("gap_latency", wr_cyc, c0 + 18);
    chk("no_err_on_clean_fills", err_cnt, 0);

    // Early beat_last on beat 9: one error pulse, count still decides the end.
    err_cnt = 0;
    do_fill_req(8'h99, c0);
    send_beats(8'h99, 32'h9999_0000, 16, 16'h8200, -1, 0);
    drain();
    chk("err_pulse_count", err_cnt, 1);
    chk("err_pulse_cycle", err_cyc, beat_cyc[9]);
    chk("err_fill_latency", wr_cyc, c0 + 16);

    // Reset after beat 7: no partial write, then a clean fill.
    do_fill_req(8'h33, c0);
    send_beats(8'h33, 32'h3333_0000, 8, 16'h0000, -1, 0);
    chk("q_empty_before_rst", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {sram_csb0, wr_busy, beat_ready}, 3'b100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_fill_req(8'h44, c0);
    send_beats(8'h44, 32'h4444_0000, 16, 16'h8000, -1, 0);
    drain();
    chk("post_rst_fill_latency", wr_cyc, c0 + 16);

    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
